// File: rtl/aes_byte_sequencer_pkg.sv
// Shared definitions for the AES byte sequencer: state encoding, block geometry
// and the default clock-derived timing constants.
package aes_byte_sequencer_pkg;

  localparam int CLK_HZ              = 50_000_000;
  localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;  // 10 ms
  localparam int DEF_AUTO_PERIOD     = CLK_HZ;        // 1 s

  localparam int BYTES_PER_BLOCK = 16;
  localparam int IDX_W           = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } seq_state_e;

  // Byte 0 is the most significant byte of the block.
  function automatic logic [7:0] block_byte(input logic [127:0] blk,
                                            input logic [IDX_W-1:0] idx);
    return blk[(BYTES_PER_BLOCK - 1 - int'(idx)) * 8 +: 8];
  endfunction

endpackage

// File: rtl/aes_byte_sequencer_key_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, stability-counter debounce and a
// one-cycle pulse on each debounced press (1 -> 0) of an active-low key.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             key_meta;
  logic             key_sync;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // NOTE: every flop here uses <=, so each one samples its pre-edge inputs and
  // the synchroniser chain cannot collapse regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
      level    <= 1'b1;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      key_meta <= key_n;
      key_sync <= key_meta;
      press    <= 1'b0;
      if (key_sync == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        // Disagreement held long enough: accept it; a 1 -> 0 flip is a press.
        level <= key_sync;
        cnt   <= '0;
        press <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_byte_sequencer.sv
// Captures a 128-bit AES block and presents it byte by byte, stepping on a
// debounced button press or an auto-scroll timer; feeds the decimal display.
module aes_byte_sequencer
  import aes_byte_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int AUTO_PERIOD     = DEF_AUTO_PERIOD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [127:0]     block_in,
  input  logic             key_next_n,
  input  logic             auto_en,
  output logic [7:0]       byte_out,
  output logic [IDX_W-1:0] byte_idx,
  output logic             busy,
  output logic             wrap
);

  localparam int AUTO_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

  seq_state_e        state;
  logic [127:0]      shadow;
  logic [AUTO_W-1:0] auto_cnt;
  logic [IDX_W-1:0]  idx_next;
  logic              press;
  logic              tick;
  logic              adv;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_next_n),
    .press (press)
  );

  assign tick     = (state == SHOW) && auto_en && (auto_cnt == AUTO_W'(AUTO_PERIOD - 1));
  assign adv      = (state == SHOW) && (press || tick);
  assign idx_next = byte_idx + 1'b1;
  assign busy     = (state == SHOW);

  // Cleared on every advance so a manual press restarts the full scroll period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_cnt <= '0;
    end else if ((state != SHOW) || !auto_en || load || adv) begin
      auto_cnt <= '0;
    end else begin
      auto_cnt <= auto_cnt + 1'b1;
    end
  end

  // NOTE: the 128-bit shadow is an ordinary register bank, not a RAM, so it is
  // reset like every other flop and no stale block survives a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shadow   <= '0;
      byte_idx <= '0;
      byte_out <= 8'h00;
      wrap     <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        // Load wins over a same-cycle advance; the advance is simply dropped.
        state    <= SHOW;
        shadow   <= block_in;
        byte_idx <= '0;
        byte_out <= block_byte(block_in, '0);
      end else if (adv) begin
        byte_idx <= idx_next;
        byte_out <= block_byte(shadow, idx_next);
        wrap     <= (byte_idx == IDX_W'(BYTES_PER_BLOCK - 1));
      end
    end
  end

endmodule

// File: tb/tb_aes_byte_sequencer.sv
// Self-checking bench for aes_byte_sequencer with short debounce/auto periods,
// compared against an index/block model of the sequencer.
module tb_aes_byte_sequencer;

  localparam int DEB  = 4;
  localparam int AUTO = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load;
  logic [127:0] block_in;
  logic         key_next_n;
  logic         auto_en;
  logic [7:0]   byte_out;
  logic [3:0]   byte_idx;
  logic         busy;
  logic         wrap;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: the loaded block, the position, and the wrap count.
  logic [127:0] m_blk;
  int           m_idx;
  bit           m_busy;
  int           m_wraps;
  int           wrap_cnt = 0;

  aes_byte_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .AUTO_PERIOD    (AUTO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .block_in  (block_in),
    .key_next_n(key_next_n),
    .auto_en   (auto_en),
    .byte_out  (byte_out),
    .byte_idx  (byte_idx),
    .busy      (busy),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && wrap) wrap_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (n_cmp=%0d)", n_cmp);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] ref_byte(input logic [127:0] blk, input int idx);
    logic [127:0] sh;
    sh = blk >> (8 * (15 - idx));
    return sh[7:0];
  endfunction

  function automatic logic [127:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".byte_out"}, {120'd0, byte_out}, {120'd0, m_busy ? ref_byte(m_blk, m_idx) : 8'h00});
    check({tag, ".byte_idx"}, {124'd0, byte_idx}, m_busy ? 128'(m_idx) : 128'd0);
    check({tag, ".busy"},     {127'd0, busy},     {127'd0, m_busy});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [127:0] blk);
    block_in = blk;
    load     = 1'b1;
    step();
    load     = 1'b0;
    m_blk    = blk;
    m_idx    = 0;
    m_busy   = 1'b1;
  endtask

  // Clean press: low 10 cycles, high 10 cycles; advances only when a block is shown.
  task automatic press_key(input string tag);
    key_next_n = 1'b0;
    repeat (10) step();
    key_next_n = 1'b1;
    repeat (10) step();
    if (m_busy) begin
      if (m_idx == 15) m_wraps++;
      m_idx = (m_idx + 1) % 16;
    end
    check_outputs(tag);
  endtask

  initial begin
    logic [127:0] blk;
    int           n_press;

    rst_n      = 1'b1;
    load       = 1'b0;
    key_next_n = 1'b1;
    auto_en    = 1'b0;
    block_in   = '0;
    m_blk      = '0;
    m_idx      = 0;
    m_busy     = 1'b0;
    m_wraps    = 0;

    // Reset asserted between edges with load pulsing: outputs cleared at once.
    #2;
    rst_n    = 1'b0;
    load     = 1'b1;
    block_in = rand_block();
    #1;
    check_outputs("reset_immediate");
    check("reset_immediate.wrap", {127'd0, wrap}, 128'd0);
    repeat (3) begin
      step();
      load = ~load;
    end
    check_outputs("reset_held_load");
    rst_n = 1'b1;
    load  = 1'b0;
    step();

    // Press while IDLE is ignored.
    press_key("idle_press");

    // Directed load of the reference block.
    do_load(128'h00112233_44556677_8899AABB_CCDDEEFF);
    check_outputs("load");
    check("load.byte_value", {120'd0, byte_out}, 128'h00);
    check("load.wrap", {127'd0, wrap}, 128'd0);

    // Three clean presses: 11, 22, 33.
    for (int i = 0; i < 3; i++) press_key("manual_step");
    check("manual_step.third_byte", {120'd0, byte_out}, 128'h33);

    // Bouncing key: never stable for DEB cycles, so no advance.
    for (int i = 0; i < 10; i++) begin
      key_next_n = ~key_next_n;
      repeat (2) step();
    end
    key_next_n = 1'b1;
    repeat (10) step();
    check_outputs("bounce_reject");

    // Auto scroll from a fresh load: one advance per AUTO cycles, wrap after 16.
    auto_en = 1'b1;
    do_load(rand_block());
    check_outputs("auto_start");
    for (int m = 1; m <= 175; m++) begin
      step();
      m_idx = (m / AUTO) % 16;
      check("auto.byte_idx", {124'd0, byte_idx}, 128'(m_idx));
      check("auto.wrap", {127'd0, wrap}, {127'd0, (m == 16 * AUTO)});
      if (m % AUTO == 0) check_outputs("auto_advance");
    end
    m_wraps++;
    check("auto.idx_before_collision", {124'd0, byte_idx}, 128'd5);

    // Load lands on the same edge as a tick at idx 5: load wins, timer restarts.
    blk = {8'hFF, rand_block()[119:0]};
    do_load(blk);
    check_outputs("collision_load");
    check("collision.byte_ff", {120'd0, byte_out}, 128'hFF);
    check("collision.wrap", {127'd0, wrap}, 128'd0);
    for (int m = 1; m <= AUTO; m++) begin
      step();
      m_idx = m / AUTO;
      check("collision.restart_idx", {124'd0, byte_idx}, 128'(m_idx));
      check("collision.restart_wrap", {127'd0, wrap}, 128'd0);
    end
    check_outputs("collision_after_period");
    auto_en = 1'b0;
    step();

    // Randomised manual runs, long enough to wrap around the block.
    for (int r = 0; r < 2; r++) begin
      do_load(rand_block());
      check_outputs("rand_load");
      n_press = $urandom_range(14, 18);
      for (int p = 0; p < n_press; p++) press_key("rand_press");
    end
    check("wrap_count", 128'(wrap_cnt), 128'(m_wraps));

    // Reset mid-sequence, between edges: everything cleared immediately.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    load  = 1'b1;
    m_busy = 1'b0;
    m_idx  = 0;
    #1;
    check_outputs("midseq_reset");
    check("midseq_reset.wrap", {127'd0, wrap}, 128'd0);
    step();
    rst_n = 1'b1;
    load  = 1'b0;
    step();
    check_outputs("post_reset_idle");

    // Press after reset, still IDLE: no change.
    press_key("post_reset_press");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
